// File: rtl/dsr_shift_pipe_n_s.sv
// Pipelined barrel shifter: left, logical and arithmetic right, sticky.
// Bubble-collapsing valid/ready stages, one register per PIPE_EVERY levels.
module dsr_shift_pipe_n_s #(
   parameter int N          = 32,
   parameter int S          = 5,
   parameter int PIPE_EVERY = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] in_data,
   input  logic [S-1:0] in_shamt,
   input  logic         in_dir,
   input  logic         in_arith,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] out_data,
   output logic         out_sticky
);

   localparam int L = (S + PIPE_EVERY - 1) / PIPE_EVERY;

   typedef struct packed {
      logic [N-1:0] d;
      logic         st;
      logic [S-1:0] sh;
      logic         dir;
      logic         ar;
   } stg_t;

   stg_t         r  [L];
   stg_t         nx [L];
   logic [L-1:0] v;
   logic [L-1:0] uv;
   logic [L-1:0] adv;

   // One shift level by a; the current msb is the sign for arithmetic
   // right shifts, since that fill keeps the msb unchanged.
   function automatic stg_t lvl(stg_t t, int a);
      logic         fill;
      logic [N-1:0] ones;
      fill = t.dir & t.ar & t.d[N-1];
      ones = '1;
      if (a >= N) begin
         t.st = t.st | (|t.d);
         t.d  = {N{fill}};
      end else if (!t.dir) begin
         t.st = t.st | (|(t.d >> (N - a)));
         t.d  = t.d << a;
      end else begin
         t.st = t.st | (|(t.d & ~(ones << a)));
         t.d  = (t.d >> a) | ({N{fill}} & ~(ones >> a));
      end
      return t;
   endfunction

   // Stage inputs from upstream, then the shift levels each stage owns.
   always_comb begin
      nx[0].d   = in_data;
      nx[0].st  = 1'b0;
      nx[0].sh  = in_shamt;
      nx[0].dir = in_dir;
      nx[0].ar  = in_arith;
      uv[0]     = in_valid;
      for (int k = 1; k < L; k++) begin
         nx[k] = r[k-1];
         uv[k] = v[k-1];
      end
      for (int k = 0; k < L; k++) begin
         for (int i = 0; i < S; i++) begin
            if ((i / PIPE_EVERY) == k && nx[k].sh[i])
               nx[k] = lvl(nx[k], 1 << i);
         end
      end
   end

   // Stage k may advance when it or any stage below it has a hole.
   always_comb begin
      adv = '0;
      for (int k = 0; k < L; k++) begin
         logic a;
         a = out_ready;
         for (int j = k; j < L; j++)
            a = a | ~v[j];
         adv[k] = a;
      end
   end

   // Stage registers; a stalled stage keeps its contents.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v <= '0;
         for (int k = 0; k < L; k++)
            r[k] <= '0;
      end else begin
         for (int k = 0; k < L; k++) begin
            if (adv[k]) begin
               v[k] <= uv[k];
               r[k] <= nx[k];
            end
         end
      end
   end

   assign in_ready   = adv[0];
   assign out_valid  = v[L-1];
   assign out_data   = r[L-1].d;
   assign out_sticky = r[L-1].st;

endmodule

// File: tb/tb_dsr_shift_pipe_n_s.sv
// Bench for dsr_shift_pipe_n_s: directed cases, backpressure, random
// stream against an arithmetic reference model and scoreboard queue.
module tb_dsr_shift_pipe_n_s;

   localparam int N = 16;
   localparam int S = 4;
   localparam int PE = 2;
   localparam int L = 2;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [N-1:0] in_data;
   logic [S-1:0] in_shamt;
   logic         in_dir;
   logic         in_arith;
   logic         out_valid;
   logic         out_ready;
   logic [N-1:0] out_data;
   logic         out_sticky;

   int nvec = 0;
   int nerr = 0;
   logic [16:0] q[$];

   dsr_shift_pipe_n_s #(.N(N), .S(S), .PIPE_EVERY(PE)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_shamt(in_shamt),
      .in_dir(in_dir), .in_arith(in_arith),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_sticky(out_sticky)
   );

   always #5 clk = ~clk;

   // Reference: {sticky, data} from wide integer shifts.
   function automatic logic [16:0] model(logic [15:0] d, logic [3:0] sh,
                                         logic dir, logic ar);
      logic [31:0]        y;
      logic signed [47:0] x;
      if (!dir) begin
         y = {16'b0, d} << sh;
         return {|y[31:16], y[15:0]};
      end
      x = ar ? {{32{d[15]}}, d} : {32'b0, d};
      x = (x <<< 16) >>> sh;
      return {|x[15:0], x[31:16]};
   endfunction

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One cycle: drive, sample before the edge, score, advance past edge.
   task automatic step(bit iv, logic [15:0] d, logic [3:0] sh,
                       bit dir, bit ar, bit ordy, output bit acc);
      in_valid  = iv;
      in_data   = d;
      in_shamt  = sh;
      in_dir    = dir;
      in_arith  = ar;
      out_ready = ordy;
      #3;
      chk("in_ready", {31'b0, in_ready},
          {31'b0, (q.size() < L) || ordy});
      if (out_valid) begin
         if (q.size() == 0) begin
            chk("spurious_out", 1, 0);
         end else begin
            chk("out", {15'b0, out_sticky, out_data}, {15'b0, q[0]});
            if (ordy) void'(q.pop_front());
         end
      end
      acc = iv && in_ready;
      if (acc) q.push_back(model(d, sh, dir, ar));
      @(posedge clk);
      #1;
   endtask

   task automatic directed(logic [15:0] d, logic [3:0] sh, bit dir,
                           bit ar, logic [15:0] ed, bit es);
      bit a;
      step(1, d, sh, dir, ar, 1, a);
      chk("accept", {31'b0, a}, 1);
      chk("lat_edge1", {31'b0, out_valid}, 0);
      step(0, 0, 0, 0, 0, 1, a);
      chk("lat_edge2", {31'b0, out_valid}, 1);
      chk("dir_data", {16'b0, out_data}, {16'b0, ed});
      chk("dir_sticky", {31'b0, out_sticky}, {31'b0, es});
      step(0, 0, 0, 0, 0, 1, a);
   endtask

   initial begin
      bit acc;
      int sent;
      int saw_full;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      in_shamt  = '0;
      in_dir    = 1'b0;
      in_arith  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1;
      chk("rst_out_valid", {31'b0, out_valid}, 0);
      chk("rst_out_data", {16'b0, out_data}, 0);
      chk("rst_out_sticky", {31'b0, out_sticky}, 0);
      chk("rst_in_ready", {31'b0, in_ready}, 1);
      rst_n = 1'b1;

      directed(16'h00F3, 4'd4, 0, 0, 16'h0F30, 0);
      directed(16'h8013, 4'd3, 1, 0, 16'h1002, 1);
      directed(16'h8010, 4'd4, 1, 1, 16'hF801, 0);
      directed(16'hC001, 4'd15, 0, 0, 16'h8000, 1);
      directed(16'hA5A5, 4'd0, 0, 0, 16'hA5A5, 0);
      directed(16'hA5A5, 4'd0, 1, 1, 16'hA5A5, 0);

      sent = 0;
      saw_full = 0;
      for (int c = 0; c < 40 && (sent < 6 || q.size() != 0); c++) begin
         if (sent >= 2 && sent < 6 && !in_ready && q.size() == L)
            saw_full++;
         step(sent < 6, 16'($urandom), 4'($urandom), 1'($urandom),
              1'($urandom), !(c >= 3 && c < 6), acc);
         if (acc) sent++;
      end
      chk("bp_sent", sent, 6);
      chk("bp_drained", q.size(), 0);
      chk("bp_full_seen", {31'b0, saw_full != 0}, 1);

      sent = 0;
      for (int c = 0; c < 40000 && sent < 10000; c++) begin
         step($urandom_range(0, 9) < 7, 16'($urandom), 4'($urandom),
              1'($urandom), 1'($urandom), $urandom_range(0, 9) < 7, acc);
         if (acc) sent++;
      end
      chk("rand_sent", sent, 10000);
      for (int c = 0; c < 20 && q.size() != 0; c++)
         step(0, 0, 0, 0, 0, 1, acc);
      chk("rand_drained", q.size(), 0);

      step(1, 16'h1234, 4'd1, 0, 0, 0, acc);
      step(1, 16'h4321, 4'd2, 1, 0, 0, acc);
      chk("inflight", q.size(), 2);
      rst_n = 1'b0;
      #1;
      chk("rst_mid_valid", {31'b0, out_valid}, 0);
      @(posedge clk);
      #1;
      chk("rst_mid_valid2", {31'b0, out_valid}, 0);
      chk("rst_mid_ready", {31'b0, in_ready}, 1);
      q.delete();
      rst_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         step(0, 0, 0, 0, 0, 1, acc);
         chk("post_rst_idle", {31'b0, out_valid}, 0);
      end
      directed(16'h0001, 4'd15, 0, 0, 16'h8000, 0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
